// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side constants and the redirect controller state encoding.
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_WAIT_REDIR,
    PC_FLUSH
  } pc_ctrl_state_t;
endpackage

// File: rtl/pc_target_gen.sv
// Redirect target selection: JALR uses the ALU sum with bit 0 cleared, branches/JAL use pc+imm.
module pc_target_gen
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] jalr_target,
  input  logic                  ex_is_jalr,
  output logic [DATA_WIDTH-1:0] target,
  output logic                  misaligned
);

  always_comb begin
    if (ex_is_jalr) target = {jalr_target[DATA_WIDTH-1:1], 1'b0};
    else            target = ex_pc + ex_imm;
    // Only 4-byte instructions are supported, so bit 1 set is a bad target.
    misaligned = target[1];
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential fetch, EX-stage redirects, wrong-path flush and misaligned-target trap.
module pc_redirect_ctrl
  import rv32_pkg::*;
#(
  parameter int                    DATA_WIDTH   = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
  parameter int                    FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic                  ex_is_jal,
  input  logic                  ex_is_jalr,
  input  logic                  Branch_taken,
  input  logic [DATA_WIDTH-1:0] JALR_target,
  input  logic                  stall_in,
  input  logic                  imem_ready,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] pc_if,
  output logic                  fetch_valid,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  redirect_busy,
  output logic                  misalign_exc,
  output logic [DATA_WIDTH-1:0] misalign_addr
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  pc_ctrl_state_t        state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] pend_target, pend_nxt;
  logic [DATA_WIDTH-1:0] target, redir_pc;
  logic [DATA_WIDTH-1:0] exc_addr_nxt;
  logic [1:0]            cnt, cnt_nxt;
  logic                  req_q, req_q_nxt;
  logic                  misaligned, redir, exc_nxt;

  pc_target_gen #(.DATA_WIDTH(DATA_WIDTH)) u_target_gen (
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .jalr_target (JALR_target),
    .ex_is_jalr  (ex_is_jalr),
    .target      (target),
    .misaligned  (misaligned)
  );

  assign redir    = ex_valid & (Branch_taken | ex_is_jal | ex_is_jalr);
  assign redir_pc = misaligned ? TRAP_VEC : target;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_nxt     = pend_target;
    cnt_nxt      = cnt;
    req_q_nxt    = req_q;
    exc_nxt      = 1'b0;
    exc_addr_nxt = misalign_addr;
    imem_req     = 1'b0;
    fetch_valid  = 1'b0;
    case (state)
      PC_RUN: begin
        imem_req = req_q | ~stall_in;
        if (redir) begin
          exc_nxt      = misaligned;
          exc_addr_nxt = target;
          if (imem_ready || !imem_req) begin
            pc_nxt    = redir_pc;
            state_nxt = PC_FLUSH;
            cnt_nxt   = CNT_INIT;
            req_q_nxt = 1'b0;
          end else begin
            // Request already on the bus must complete with a stable address.
            pend_nxt  = redir_pc;
            state_nxt = PC_WAIT_REDIR;
            req_q_nxt = 1'b1;
          end
        end else if (imem_req) begin
          if (imem_ready) begin
            pc_nxt      = pc + DATA_WIDTH'(INSN_BYTES);
            req_q_nxt   = 1'b0;
            fetch_valid = 1'b1;
          end else begin
            req_q_nxt = 1'b1;
          end
        end
      end
      PC_WAIT_REDIR: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_nxt    = pend_target;
          state_nxt = PC_FLUSH;
          cnt_nxt   = CNT_INIT;
          req_q_nxt = 1'b0;
        end
      end
      PC_FLUSH: begin
        if (cnt == 2'd0) state_nxt = PC_RUN;
        else             cnt_nxt   = cnt - 2'd1;
      end
      default: state_nxt = PC_RUN;
    endcase
    if (!rst_n) begin
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= PC_RUN;
      pc            <= RESET_PC;
      cnt           <= 2'd0;
      req_q         <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      cnt           <= cnt_nxt;
      req_q         <= req_q_nxt;
      misalign_exc  <= exc_nxt;
      misalign_addr <= exc_addr_nxt;
    end
  end

  // Pending target is only meaningful in PC_WAIT_REDIR, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_target <= pend_nxt;
  end

  assign imem_addr     = pc;
  assign pc_if         = pc;
  assign redirect_busy = (state != PC_RUN);
  assign flush_if_id   = (state != PC_RUN);
  assign flush_id_ex   = (state != PC_RUN);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: fetch, redirects, imem back-pressure, stall, misalign and reset.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        Branch_taken;
  logic [31:0] JALR_target;
  logic        stall_in;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_if;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_busy;
  logic        misalign_exc;
  logic [31:0] misalign_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_is_jal     (ex_is_jal),
    .ex_is_jalr    (ex_is_jalr),
    .Branch_taken  (Branch_taken),
    .JALR_target   (JALR_target),
    .stall_in      (stall_in),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .pc_if         (pc_if),
    .fetch_valid   (fetch_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .redirect_busy (redirect_busy),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ex();
    ex_valid     = 1'b0;
    ex_is_jal    = 1'b0;
    ex_is_jalr   = 1'b0;
    Branch_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; imem_ready = 1'b1;
    ex_pc = '0; ex_imm = '0; JALR_target = '0;
    clear_ex();

    // 1. reset, then sequential fetch
    tick(); tick(); #1;
    chk("rst_pc", pc_if, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    chk("rst_busy_exc", {30'b0, redirect_busy, misalign_exc}, 32'h0);
    rst_n = 1'b1; #1;
    chk("seq_addr0", imem_addr, 32'h0);
    chk("seq_req_fv0", {30'b0, imem_req, fetch_valid}, 32'h3);
    tick(); chk("seq_addr4", imem_addr, 32'h4);
    tick(); chk("seq_addr8", imem_addr, 32'h8);

    // 2. taken branch 0x100+0x20
    ex_valid = 1'b1; Branch_taken = 1'b1; ex_pc = 32'h100; ex_imm = 32'h20; #1;
    chk("br_fv_N", {31'b0, fetch_valid}, 32'h0);
    tick(); clear_ex(); #1;
    chk("br_pc_N1", pc_if, 32'h120);
    chk("br_flush_N1", {30'b0, flush_if_id, flush_id_ex}, 32'h3);
    chk("br_req_N1", {31'b0, imem_req}, 32'h0);
    chk("br_exc_N1", {31'b0, misalign_exc}, 32'h0);
    tick();
    chk("br_req_N2", {31'b0, imem_req}, 32'h1);
    chk("br_addr_N2", imem_addr, 32'h120);
    chk("br_flush_N2", {30'b0, flush_if_id, flush_id_ex}, 32'h0);

    // 3a. aligned JALR, bit 0 cleared
    ex_valid = 1'b1; ex_is_jalr = 1'b1; JALR_target = 32'h209;
    tick(); clear_ex(); #1;
    chk("jalr_pc", pc_if, 32'h208);
    chk("jalr_exc", {31'b0, misalign_exc}, 32'h0);
    tick();

    // 3b. misaligned JALR traps
    ex_valid = 1'b1; ex_is_jalr = 1'b1; JALR_target = 32'h206;
    tick(); clear_ex(); #1;
    chk("mis_exc", {31'b0, misalign_exc}, 32'h1);
    chk("mis_addr", misalign_addr, 32'h206);
    chk("mis_pc", pc_if, 32'h100);
    tick();
    chk("mis_exc_pulse", {31'b0, misalign_exc}, 32'h0);
    chk("mis_run_addr", {imem_addr[30:0], imem_req}, {31'h100, 1'b1});

    // 4. redirect while imem not ready
    imem_ready = 1'b0;
    tick();
    chk("wr_hold_pc", pc_if, 32'h100);
    ex_valid = 1'b1; Branch_taken = 1'b1; ex_pc = 32'h300; ex_imm = 32'h40; #1;
    chk("wr_fv_N", {31'b0, fetch_valid}, 32'h0);
    tick(); clear_ex(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("wr_addr", imem_addr, 32'h100);
      chk("wr_req_fv", {30'b0, imem_req, fetch_valid}, 32'h2);
      chk("wr_flush_busy", {29'b0, flush_if_id, flush_id_ex, redirect_busy}, 32'h7);
      tick();
    end
    imem_ready = 1'b1; #1;
    chk("wr_fv_ready", {31'b0, fetch_valid}, 32'h0);
    tick();
    chk("wr_flush_pc", pc_if, 32'h340);
    chk("wr_flush_req", {30'b0, imem_req, flush_if_id}, 32'h1);
    tick();
    chk("wr_run_addr", imem_addr, 32'h340);
    chk("wr_run_req_fv", {29'b0, imem_req, fetch_valid, flush_id_ex}, 32'h6);

    // 5. stall, JAL during stall with address wrap
    stall_in = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_req", {31'b0, imem_req}, 32'h0);
      chk("st_pc", pc_if, 32'h340);
      tick();
    end
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20; #1;
    chk("st_jal_fv", {31'b0, fetch_valid}, 32'h0);
    tick(); clear_ex(); #1;
    chk("st_jal_pc", pc_if, 32'h10);
    chk("st_jal_flush", {31'b0, flush_if_id}, 32'h1);
    tick();
    chk("st_run_req", {31'b0, imem_req}, 32'h0);
    stall_in = 1'b0; #1;
    chk("st_rel_addr", {imem_addr[30:0], imem_req}, {31'h10, 1'b1});

    // 6a. reset during PC_WAIT_REDIR
    imem_ready = 1'b0;
    tick();
    ex_valid = 1'b1; Branch_taken = 1'b1; ex_pc = 32'h500; ex_imm = 32'h10;
    tick(); clear_ex(); #1;
    chk("rw_busy", {31'b0, redirect_busy}, 32'h1);
    rst_n = 1'b0; #1;
    chk("rw_req_in_rst", {31'b0, imem_req}, 32'h0);
    tick();
    chk("rw_pc", pc_if, 32'h0);
    chk("rw_flush", {29'b0, flush_if_id, flush_id_ex, redirect_busy}, 32'h0);
    rst_n = 1'b1; imem_ready = 1'b1; #1;
    chk("rw_req_addr", {imem_addr[30:0], imem_req}, {31'h0, 1'b1});
    tick();
    chk("rw_seq", pc_if, 32'h4);

    // 6b. reset during PC_FLUSH
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'h40; ex_imm = 32'h80;
    tick(); clear_ex(); #1;
    chk("rf_flush_pc", pc_if, 32'hC0);
    rst_n = 1'b0;
    tick();
    chk("rf_pc", pc_if, 32'h0);
    chk("rf_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rf_seq", pc_if, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
